// File: rtl/instr_decode_stage_if.sv
// -----------------------------------------------------------------------------
// instr_decode_stage_if
// Bundles the fetch-side inputs and the decoded ID-register outputs of the
// 8-bit processor's decode stage.
//   master : the surrounding pipeline / bench (drives fetch and execute inputs)
//   slave  : instr_decode_stage (drives fetch_stall and every id_* output)
// Fetch side   : if_instr[15:0], if_pc, if_valid, ex_stall, flush, fetch_stall
// Decode side  : id_valid, id_pc, id_opcode, id_rd/rs/rt, id_funct, id_imm,
//                id_jump_off, id_reg_write, id_mem_read, id_mem_write,
//                id_alu_src_imm, id_branch, id_jump, id_illegal, id_alu_op
// Optional     : perf_decoded/perf_bubbles/perf_flushes when DECODE_PERF_EN
//                is defined.
// -----------------------------------------------------------------------------
interface instr_decode_stage_if #(
  parameter int PC_WIDTH  = 6,
  parameter int IMM_WIDTH = 8
);
  logic [15:0]          if_instr;
  logic [PC_WIDTH-1:0]  if_pc;
  logic                 if_valid;
  logic                 ex_stall;
  logic                 flush;
  logic                 fetch_stall;

  logic                 id_valid;
  logic [PC_WIDTH-1:0]  id_pc;
  logic [3:0]           id_opcode;
  logic [2:0]           id_rd;
  logic [2:0]           id_rs;
  logic [2:0]           id_rt;
  logic [2:0]           id_funct;
  logic [IMM_WIDTH-1:0] id_imm;
  logic [IMM_WIDTH-1:0] id_jump_off;
  logic                 id_reg_write;
  logic                 id_mem_read;
  logic                 id_mem_write;
  logic                 id_alu_src_imm;
  logic                 id_branch;
  logic                 id_jump;
  logic                 id_illegal;
  logic [2:0]           id_alu_op;
`ifdef DECODE_PERF_EN
  logic [15:0]          perf_decoded;
  logic [15:0]          perf_bubbles;
  logic [15:0]          perf_flushes;
`endif

  modport master (
    output if_instr, if_pc, if_valid, ex_stall, flush,
    input  fetch_stall,
    input  id_valid, id_pc, id_opcode, id_rd, id_rs, id_rt, id_funct,
    input  id_imm, id_jump_off, id_reg_write, id_mem_read, id_mem_write,
    input  id_alu_src_imm, id_branch, id_jump, id_illegal, id_alu_op
`ifdef DECODE_PERF_EN
    , input perf_decoded, perf_bubbles, perf_flushes
`endif
  );

  modport slave (
    input  if_instr, if_pc, if_valid, ex_stall, flush,
    output fetch_stall,
    output id_valid, id_pc, id_opcode, id_rd, id_rs, id_rt, id_funct,
    output id_imm, id_jump_off, id_reg_write, id_mem_read, id_mem_write,
    output id_alu_src_imm, id_branch, id_jump, id_illegal, id_alu_op
`ifdef DECODE_PERF_EN
    , output perf_decoded, perf_bubbles, perf_flushes
`endif
  );
endinterface

// File: rtl/instr_decode_stage.sv
// -----------------------------------------------------------------------------
// instr_decode_stage
// IF/ID pipeline register plus instruction decoder for the 8-bit processor.
// Registers the opcode/register fields, sign-extended immediate, jump offset
// and decoded control signals one cycle after fetch presents them, and
// detects load-use hazards: while the instruction in ID is a load whose rd is
// read by the incoming instruction, fetch_stall holds fetch and a single
// bubble is sent toward execute.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   dec  - instr_decode_stage_if.slave (fetch inputs, fetch_stall, id_* outputs)
// Parameters:
//   PC_WIDTH      - width of the PC carried with the instruction
//   IMM_WIDTH     - width of id_imm / id_jump_off (must be >= 8)
//   HAZARD_DETECT - 1 enables load-use detection, 0 ties fetch_stall low
// Optional feature macro: DECODE_PERF_EN adds saturating 16-bit counters
//   perf_decoded, perf_bubbles and perf_flushes on the interface.
// -----------------------------------------------------------------------------
module instr_decode_stage #(
  parameter int PC_WIDTH      = 6,
  parameter int IMM_WIDTH     = 8,
  parameter bit HAZARD_DETECT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_decode_stage_if.slave   dec
);

  // Opcodes of the supported instruction formats
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b1011;
  localparam logic [3:0] OP_SW    = 4'b1111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_JUMP  = 4'b0010;

  // Bit positions inside the packed control vector
  localparam int CTL_REG_WRITE = 9;
  localparam int CTL_MEM_READ  = 8;
  localparam int CTL_MEM_WRITE = 7;
  localparam int CTL_ALU_SRC   = 6;
  localparam int CTL_BRANCH    = 5;
  localparam int CTL_JUMP      = 4;
  localparam int CTL_ILLEGAL   = 3;

  // Opcode -> {reg_write, mem_read, mem_write, alu_src_imm, branch, jump,
  // illegal, alu_op[2:0]}
  function automatic logic [9:0] decode_ctrl(input logic [15:0] instr);
    logic [9:0] c;
    c = 10'd0;
    case (instr[15:12])
      OP_RTYPE: begin
        // funct 111 is the NOP encoding and never writes a register
        c[CTL_REG_WRITE] = (instr[2:0] != 3'b111);
        c[2:0]           = instr[2:0];
      end
      OP_ADDI: begin
        c[CTL_REG_WRITE] = 1'b1;
        c[CTL_ALU_SRC]   = 1'b1;
        c[2:0]           = 3'b000;
      end
      OP_LW: begin
        c[CTL_REG_WRITE] = 1'b1;
        c[CTL_MEM_READ]  = 1'b1;
        c[CTL_ALU_SRC]   = 1'b1;
        c[2:0]           = 3'b000;
      end
      OP_SW: begin
        c[CTL_MEM_WRITE] = 1'b1;
        c[CTL_ALU_SRC]   = 1'b1;
        c[2:0]           = 3'b000;
      end
      OP_BEQ: begin
        c[CTL_BRANCH] = 1'b1;
        c[2:0]        = 3'b001;
      end
      OP_JUMP: begin
        c[CTL_JUMP] = 1'b1;
      end
      default: begin
        c[CTL_ILLEGAL] = 1'b1;
      end
    endcase
    return c;
  endfunction

  // Which register fields the instruction reads: {uses_rd, uses_rs, uses_rt}
  function automatic logic [2:0] src_usage(input logic [3:0] opcode);
    logic [2:0] u;
    u = 3'b000;
    case (opcode)
      OP_RTYPE: u = 3'b011;
      OP_ADDI:  u = 3'b010;
      OP_LW:    u = 3'b010;
      OP_SW:    u = 3'b110;
      OP_BEQ:   u = 3'b110;
      OP_JUMP:  u = 3'b000;
      default:  u = 3'b000;
    endcase
    return u;
  endfunction

  logic                 id_valid_r;
  logic [PC_WIDTH-1:0]  id_pc_r;
  logic [3:0]           id_opcode_r;
  logic [2:0]           id_rd_r;
  logic [2:0]           id_rs_r;
  logic [2:0]           id_rt_r;
  logic [2:0]           id_funct_r;
  logic [IMM_WIDTH-1:0] id_imm_r;
  logic [IMM_WIDTH-1:0] id_jump_off_r;
  logic [9:0]           ctrl_r;

  logic [9:0]           load_ctrl_s;
  logic [2:0]           load_funct_s;
  logic [IMM_WIDTH-1:0] load_imm_s;
  logic [IMM_WIDTH-1:0] load_jump_off_s;
  logic                 hazard_s;

  // Decode the incoming word; controls are gated off for an invalid slot
  always_comb begin
    load_ctrl_s     = 10'd0;
    load_funct_s    = 3'b000;
    load_imm_s      = IMM_WIDTH'($signed(dec.if_instr[5:0]));
    load_jump_off_s = IMM_WIDTH'(dec.if_instr[7:0]);
    if (dec.if_valid) begin
      load_ctrl_s = decode_ctrl(dec.if_instr);
    end else begin
      load_ctrl_s = 10'd0;
    end
    if (dec.if_instr[15:12] == OP_RTYPE) begin
      load_funct_s = dec.if_instr[2:0];
    end else begin
      load_funct_s = 3'b000;
    end
  end

  generate
    if (HAZARD_DETECT) begin : g_hazard
      logic [2:0] use_s;

      // Load-use check: ID holds a load whose rd is a source of if_instr
      always_comb begin
        use_s    = src_usage(dec.if_instr[15:12]);
        hazard_s = 1'b0;
        if (dec.if_valid && id_valid_r && ctrl_r[CTL_MEM_READ]) begin
          hazard_s = (use_s[2] && (id_rd_r == dec.if_instr[11:9])) ||
                     (use_s[1] && (id_rd_r == dec.if_instr[8:6]))  ||
                     (use_s[0] && (id_rd_r == dec.if_instr[5:3]));
        end else begin
          hazard_s = 1'b0;
        end
      end
    end else begin : g_no_hazard
      assign hazard_s = 1'b0;
    end
  endgenerate

  // A flush or an execute stall already holds fetch, so neither needs a bubble
  assign dec.fetch_stall = hazard_s & ~dec.ex_stall & ~dec.flush & ~rst;

  // ID register: rst > flush > ex_stall hold > hazard bubble > normal load
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_r    <= 1'b0;
      id_pc_r       <= '0;
      id_opcode_r   <= 4'd0;
      id_rd_r       <= 3'd0;
      id_rs_r       <= 3'd0;
      id_rt_r       <= 3'd0;
      id_funct_r    <= 3'd0;
      id_imm_r      <= '0;
      id_jump_off_r <= '0;
      ctrl_r        <= 10'd0;
    end else if (dec.flush) begin
      id_valid_r <= 1'b0;
      ctrl_r     <= 10'd0;
    end else if (dec.ex_stall) begin
      id_valid_r <= id_valid_r;
      ctrl_r     <= ctrl_r;
    end else if (hazard_s) begin
      // Bubble: the held instruction reloads next cycle once id_valid is 0
      id_valid_r <= 1'b0;
      ctrl_r     <= 10'd0;
    end else begin
      id_valid_r    <= dec.if_valid;
      id_pc_r       <= dec.if_pc;
      id_opcode_r   <= dec.if_instr[15:12];
      id_rd_r       <= dec.if_instr[11:9];
      id_rs_r       <= dec.if_instr[8:6];
      id_rt_r       <= dec.if_instr[5:3];
      id_funct_r    <= load_funct_s;
      id_imm_r      <= load_imm_s;
      id_jump_off_r <= load_jump_off_s;
      ctrl_r        <= load_ctrl_s;
    end
  end

  assign dec.id_valid       = id_valid_r;
  assign dec.id_pc          = id_pc_r;
  assign dec.id_opcode      = id_opcode_r;
  assign dec.id_rd          = id_rd_r;
  assign dec.id_rs          = id_rs_r;
  assign dec.id_rt          = id_rt_r;
  assign dec.id_funct       = id_funct_r;
  assign dec.id_imm         = id_imm_r;
  assign dec.id_jump_off    = id_jump_off_r;
  assign dec.id_reg_write   = ctrl_r[CTL_REG_WRITE];
  assign dec.id_mem_read    = ctrl_r[CTL_MEM_READ];
  assign dec.id_mem_write   = ctrl_r[CTL_MEM_WRITE];
  assign dec.id_alu_src_imm = ctrl_r[CTL_ALU_SRC];
  assign dec.id_branch      = ctrl_r[CTL_BRANCH];
  assign dec.id_jump        = ctrl_r[CTL_JUMP];
  assign dec.id_illegal     = ctrl_r[CTL_ILLEGAL];
  assign dec.id_alu_op      = ctrl_r[2:0];

`ifdef DECODE_PERF_EN
  logic [15:0] perf_decoded_r;
  logic [15:0] perf_bubbles_r;
  logic [15:0] perf_flushes_r;

  // Saturating event counters following the same priority as the ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_decoded_r <= 16'd0;
      perf_bubbles_r <= 16'd0;
      perf_flushes_r <= 16'd0;
    end else if (dec.flush) begin
      if (perf_flushes_r != 16'hFFFF) perf_flushes_r <= perf_flushes_r + 16'd1;
    end else if (dec.ex_stall) begin
      perf_decoded_r <= perf_decoded_r;
    end else if (hazard_s) begin
      if (perf_bubbles_r != 16'hFFFF) perf_bubbles_r <= perf_bubbles_r + 16'd1;
    end else if (dec.if_valid) begin
      if (perf_decoded_r != 16'hFFFF) perf_decoded_r <= perf_decoded_r + 16'd1;
    end
  end

  assign dec.perf_decoded = perf_decoded_r;
  assign dec.perf_bubbles = perf_bubbles_r;
  assign dec.perf_flushes = perf_flushes_r;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_stage
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of the decode stage kept in this bench.
// -----------------------------------------------------------------------------
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_decode_stage_if #(.PC_WIDTH(6), .IMM_WIDTH(8)) bus ();

  instr_decode_stage #(.PC_WIDTH(6), .IMM_WIDTH(8), .HAZARD_DETECT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .dec (bus.slave)
  );

  typedef struct packed {
    logic       rw;
    logic       mr;
    logic       mw;
    logic       asi;
    logic       br;
    logic       jp;
    logic       il;
    logic [2:0] alu;
  } ctrl_t;

  int n_cmp = 0;
  int n_mis = 0;

  // Model of the ID register contents
  logic       m_valid;
  logic [5:0] m_pc;
  logic [3:0] m_op;
  logic [2:0] m_rd, m_rs, m_rt, m_funct;
  logic [7:0] m_imm, m_joff;
  ctrl_t      m_ctrl;
  logic       m_known;   // fields are defined (after reset or a real load)

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Controls straight from the instruction-set table
  function automatic ctrl_t ref_ctrl(input logic [15:0] w);
    ctrl_t c;
    int op;
    int f;
    c  = '0;
    op = int'(w[15:12]);
    f  = int'(w[2:0]);
    if (op == 0) begin
      c.rw = (f != 7);
      c.alu = w[2:0];
    end else if (op == 4) begin
      c.rw = 1'b1; c.asi = 1'b1;
    end else if (op == 11) begin
      c.rw = 1'b1; c.mr = 1'b1; c.asi = 1'b1;
    end else if (op == 15) begin
      c.mw = 1'b1; c.asi = 1'b1;
    end else if (op == 8) begin
      c.br = 1'b1; c.alu = 3'b001;
    end else if (op == 2) begin
      c.jp = 1'b1;
    end else begin
      c.il = 1'b1;
    end
    return c;
  endfunction

  // Load-use: does the word read the register the load in ID writes?
  function automatic logic ref_hazard(input logic [15:0] w, input logic v);
    int srcs[$];
    int op;
    op = int'(w[15:12]);
    if (op == 0) begin
      srcs.push_back(int'(w[8:6])); srcs.push_back(int'(w[5:3]));
    end else if (op == 4 || op == 11) begin
      srcs.push_back(int'(w[8:6]));
    end else if (op == 15 || op == 8) begin
      srcs.push_back(int'(w[11:9])); srcs.push_back(int'(w[8:6]));
    end
    if (!(v && m_valid && m_ctrl.mr)) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == int'(m_rd)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = 6'd0; m_op = 4'd0; m_rd = 3'd0; m_rs = 3'd0;
    m_rt = 3'd0; m_funct = 3'd0; m_imm = 8'd0; m_joff = 8'd0; m_ctrl = '0;
    m_known = 1'b1;
  endtask

  logic last_stall;

  // One clock: drive inputs, check fetch_stall, clock, check ID outputs
  task automatic cycle(input logic [15:0] w, input logic [5:0] pc, input logic v,
                       input logic st, input logic fl, input logic r);
    logic hz;
    bus.if_instr = w; bus.if_pc = pc; bus.if_valid = v;
    bus.ex_stall = st; bus.flush = fl; rst = r;
    #1;
    hz = ref_hazard(w, v);
    last_stall = hz & ~st & ~fl;
    if (!r) chk("fetch_stall", 64'(bus.fetch_stall), 64'(last_stall));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (fl) begin
      m_valid = 1'b0; m_ctrl = '0; m_known = 1'b0;
    end else if (st) begin
      m_valid = m_valid;
    end else if (hz) begin
      m_valid = 1'b0; m_ctrl = '0; m_known = 1'b0;
    end else begin
      m_valid = v; m_pc = pc; m_op = w[15:12];
      m_rd = w[11:9]; m_rs = w[8:6]; m_rt = w[5:3];
      m_funct = (w[15:12] == 4'd0) ? w[2:0] : 3'd0;
      m_imm = {{2{w[5]}}, w[5:0]};
      m_joff = w[7:0];
      m_ctrl = v ? ref_ctrl(w) : '0;
      m_known = 1'b1;
    end
    @(negedge clk);
    chk("valid_ctrl",
        64'({bus.id_valid, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
             bus.id_alu_src_imm, bus.id_branch, bus.id_jump, bus.id_illegal, bus.id_alu_op}),
        64'({m_valid, m_ctrl}));
    if (m_known)
      chk("fields",
          64'({bus.id_pc, bus.id_opcode, bus.id_rd, bus.id_rs, bus.id_rt,
               bus.id_funct, bus.id_imm, bus.id_jump_off}),
          64'({m_pc, m_op, m_rd, m_rs, m_rt, m_funct, m_imm, m_joff}));
  endtask

  localparam logic [15:0] W_ADDI = 16'b0100_111_111_001111;
  localparam logic [15:0] W_BEQ  = 16'b1000_000_001_111010;
  localparam logic [15:0] W_LW   = 16'b1011_011_000_000001;
  localparam logic [15:0] W_ADD  = 16'b0000_010_011_000_000;
  localparam logic [15:0] W_SW   = 16'b1111_001_010_000100;
  localparam logic [15:0] W_ILL  = 16'b0001_010_011_100101;
  localparam logic [15:0] W_JMP  = 16'b0010_0011_00000011;

  initial begin
    logic [15:0] w;
    logic [3:0]  ops [8];
    logic        v, st, fl, r;
    model_reset();
    last_stall = 1'b0;
    bus.if_instr = 16'd0; bus.if_pc = 6'd0; bus.if_valid = 1'b0;
    bus.ex_stall = 1'b0; bus.flush = 1'b0;

    // Reset state
    cycle(16'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_valid", 64'(bus.id_valid), 64'd0);
    chk("reset_fetch_stall", 64'(bus.fetch_stall), 64'd0);

    // ADDI with positive immediate
    cycle(W_ADDI, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("addi_rd_rs", 64'({bus.id_rd, bus.id_rs}), 64'({3'd7, 3'd7}));
    chk("addi_imm", 64'(bus.id_imm), 64'(8'h0F));
    chk("addi_ctl", 64'({bus.id_valid, bus.id_reg_write, bus.id_alu_src_imm}), 64'(3'b111));

    // BEQ with negative immediate
    cycle(W_BEQ, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("beq_imm", 64'(bus.id_imm), 64'(8'hFA));
    chk("beq_ctl", 64'({bus.id_branch, bus.id_reg_write, bus.id_alu_op}), 64'({1'b1, 1'b0, 3'b001}));

    // Load-use: one stall cycle, one bubble, then the ADD
    cycle(W_LW, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(W_ADD, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_stall_seen", 64'(last_stall), 64'd1);
    chk("lu_bubble", 64'(bus.id_valid), 64'd0);
    cycle(W_ADD, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_add", 64'({bus.id_valid, bus.id_rs, bus.id_alu_op}), 64'({1'b1, 3'd3, 3'b000}));

    // Flush wins over ex_stall
    cycle(W_SW, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sw_mw", 64'(bus.id_mem_write), 64'd1);
    cycle(W_ADDI, 6'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_stall", 64'({bus.id_valid, bus.id_mem_write}), 64'd0);

    // Illegal opcode and JUMP
    cycle(W_ILL, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("illegal", 64'({bus.id_valid, bus.id_illegal, bus.id_reg_write, bus.id_alu_op}),
        64'({1'b1, 1'b1, 1'b0, 3'b000}));
    cycle(W_JMP, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("jump", 64'({bus.id_jump, bus.id_jump_off}), 64'({1'b1, 8'h03}));

    // Reset in the stall cycle clears everything
    cycle(W_LW, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(W_ADD, 6'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_hazard_all",
        64'({bus.id_valid, bus.id_pc, bus.id_opcode, bus.id_rd, bus.id_imm,
             bus.id_mem_read, bus.id_reg_write}), 64'd0);
    cycle(W_ADD, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_hazard_nostall", 64'(last_stall), 64'd0);

    // Randomized traffic; fetch honours the model's stall by repeating the word
    ops[0] = 4'd0; ops[1] = 4'd4; ops[2] = 4'd11; ops[3] = 4'd11;
    ops[4] = 4'd15; ops[5] = 4'd8; ops[6] = 4'd2; ops[7] = 4'd9;
    w = 16'd0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        w = 16'($urandom);
        w[15:12] = ops[$urandom_range(0, 7)];
        w[11:9]  = 3'($urandom_range(0, 3));
        w[8:6]   = 3'($urandom_range(0, 3));
        w[5:3]   = 3'($urandom_range(0, 3));
      end
      v  = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 9) < 2);
      fl = ($urandom_range(0, 19) < 2);
      r  = ($urandom_range(0, 49) == 0);
      cycle(w, 6'($urandom), v, st, fl, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- IF/ID pipeline register plus decoder for the 8-bit processor.
- Consumes the 16-bit word and 6-bit PC from the instruction fetch/PC stage.
- Registers the decoded fields and control signals, and sign-extends immediates.
- Detects load-use hazards and holds fetch while it inserts one bubble toward execute.

Parameters:
- PC_WIDTH, 6, width of PC carried with the instruction
- IMM_WIDTH, 8, width of the sign-extended immediate and jump offset outputs
- HAZARD_DETECT, 1, 1 = load-use detection active; 0 = fetch_stall tied 0 and no bubbles inserted

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_instr  in  16  instruction word from fetch
- if_pc  in  PC_WIDTH  PC of if_instr
- if_valid  in  1  if_instr is meaningful this cycle
- ex_stall  in  1  execute cannot accept; hold the ID register
- flush  in  1  taken branch/jump; squash the ID contents
- fetch_stall  out  1  combinational; fetch must hold its PC/instruction this cycle
- id_valid  out  1  ID register holds a real instruction
- id_pc  out  PC_WIDTH  registered PC
- id_opcode  out  4  instr[15:12]
- id_rd, id_rs, id_rt  out  3 each  instr[11:9], [8:6], [5:3]
- id_funct  out  3  instr[2:0]; R-type only, else 0
- id_imm  out  IMM_WIDTH  instr[5:0] sign-extended
- id_jump_off  out  IMM_WIDTH  instr[7:0], zero-extended if IMM_WIDTH > 8
- id_reg_write, id_mem_read, id_mem_write, id_alu_src_imm, id_branch, id_jump, id_illegal  out  1 each  decoded controls
- id_alu_op  out  3  ALU function

Behaviour:
- Reset: all id_* outputs 0; fetch_stall 0.
- Decode table (opcode -> controls):
  - 0000 R-type: reg_write=1; alu_op=funct (ADD 000, SUB 001, AND 010, OR 011, EOR 100, BIC 101, RSB 110). funct 111 is a NOP: reg_write=0.
  - 0100 ADDI: reg_write=1, alu_src_imm=1, alu_op=000.
  - 1011 LW: reg_write=1, mem_read=1, alu_src_imm=1, alu_op=000.
  - 1111 SW: mem_write=1, alu_src_imm=1, alu_op=000.
  - 1000 BEQ: branch=1, alu_op=001.
  - 0010 JUMP: jump=1.
  - Any other opcode: illegal=1, all other controls 0, id_valid still 1.
- Source registers per format:
  - R-type: rs, rt.
  - ADDI, LW: rs.
  - SW, BEQ: rd and rs.
  - JUMP: none.
- Hazard (HAZARD_DETECT=1): hazard = if_valid & id_valid & id_mem_read & (id_rd equals any source register used by if_instr). fetch_stall = hazard & ~ex_stall & ~flush.
- Register update priority, evaluated each rising edge:
  1. rst: clear all.
  2. flush: id_valid<=0, controls<=0. Wins over ex_stall and hazard.
  3. ex_stall: hold every id_* value.
  4. hazard: load a bubble (id_valid=0, all controls 0; fields don't-care).
  5. Otherwise: id_valid<=if_valid; fields and controls load from if_instr, with controls gated to 0 when if_valid=0.
- Latency: 1 cycle from if_instr to id_*.
- A hazard bubble lasts exactly one cycle. The next cycle id_valid=0, so no hazard, and the held instruction loads.
- Every control output is 0 whenever id_valid=0.
- Sign extension: id_imm = {{(IMM_WIDTH-6){instr[5]}}, instr[5:0]}. Example: 6'b111111 -> 8'hFF.
- id_jump_off is the 8-bit PC-relative offset.
- Reset asserted mid-stall or mid-hazard clears immediately; there are no residual bubbles.

Optional Feature:
- Macro: DECODE_PERF_EN.
- When defined, adds three 16-bit outputs, each reset to 0 and saturating at 16'hFFFF:
  - perf_decoded: increments on each cycle a valid instruction loads.
  - perf_bubbles: increments on each hazard bubble.
  - perf_flushes: increments on each flush cycle.
- When undefined, these ports and registers are absent, and all behaviour above is unchanged.

Test Plan:
- ADDI decode: reset, then if_instr=16'b0100_111_111_001111, if_valid=1 -> next cycle id_valid=1, reg_write=1, alu_src_imm=1, id_rd=7, id_rs=7, id_imm=8'h0F.
- Negative immediate: BEQ 16'b1000_000_001_111010 -> branch=1, alu_op=001, id_imm=8'hFA, reg_write=0.
- Load-use: LW rd=3 (16'b1011_011_000_000001), then ADD rs=3 (16'b0000_010_011_000_000) -> fetch_stall=1 for one cycle, a bubble (id_valid=0), then the ADD appears with alu_op=000.
- Flush over stall: load SW, then assert ex_stall=1 and flush=1 together -> id_valid=0 and mem_write=0 next cycle.
- Illegal and JUMP: opcode 0001 -> illegal=1, all other controls 0. JUMP 16'b0010_0011_00000011 -> jump=1, id_jump_off=8'h03.
- Reset mid-hazard: LW then dependent ADD, assert rst in the stall cycle -> next cycle all id_* = 0, fetch_stall=0.
